lfsr_prbs_mon: RTL and testbench

// Self-synchronising multi-bit PRBS monitor: the receive-side companion to the lfsr_prbs generator.
// - Predicts each incoming word from previously received bits, using the same LFSR polynomial.
// - Flags per-bit mismatches and runs a HUNT/LOCKED state machine.
// - Keeps saturating error-word and (optional) error-bit counters.
// - Sits after SERDES/loopback data paths for link BER testing.
//

---
 rtl/lfsr_prbs_mon.sv | 180 ++++++++++++++++++
 tb/tb_lfsr_prbs_mon.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_mon.sv
// rtl/lfsr_prbs_mon.sv - self-synchronising PRBS monitor with HUNT/LOCKED tracking and saturating error counters
// Optional PRBS_MON_BER_EN adds the popcount-based err_bit_cnt; without it err_bit_cnt reads 0.
module lfsr_prbs_mon #(
    parameter int                    LFSR_WIDTH  = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
    parameter string                 LFSR_CONFIG = "FIBONACCI",
    parameter int                    REVERSE     = 0,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    LOCK_COUNT  = 16,
    parameter int                    UNLOCK_ERRS = 8,
    parameter int                    CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear_cnt,
    output logic [DATA_WIDTH-1:0] err_out,
    output logic                  err_valid,
    output logic                  locked,
    output logic [CNT_WIDTH-1:0]  err_word_cnt,
    output logic [CNT_WIDTH-1:0]  err_bit_cnt
);

    localparam int W       = LFSR_WIDTH;
    localparam int D       = DATA_WIDTH;
    localparam logic FIB_OK = (LFSR_CONFIG == "FIBONACCI");
    localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_ERRS) ? LOCK_COUNT : UNLOCK_ERRS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_COUNT - 1);
    localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_ERRS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic [W-1:0]           hist_q, hist_d;
    logic [D-1:0]           err_out_q, err_out_d;
    logic                   err_valid_q, err_valid_d;
    logic [CNT_WIDTH-1:0]   err_word_cnt_q, err_word_cnt_d;

    // seq holds history (oldest at bit 0) followed by the current word in arrival order
    logic [W+D-1:0] seq;
    logic [D-1:0]   err_vec;
    logic [W-1:0]   hist_next;
    logic           pred_bit;
    logic           word_err;
    logic           count_en;

    always_comb begin
        seq = '0;
        seq[W-1:0] = hist_q;
        for (int j = 0; j < D; j++) begin
            seq[W+j] = (REVERSE != 0) ? data_in[D-1-j] : data_in[j];
        end
        err_vec  = '0;
        pred_bit = 1'b0;
        for (int j = 0; j < D; j++) begin
            pred_bit = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (LFSR_POLY[i]) begin
                    pred_bit = pred_bit ^ seq[j+i];
                end
            end
            if (REVERSE != 0) begin
                err_vec[D-1-j] = seq[W+j] ^ (pred_bit & FIB_OK);
            end else begin
                err_vec[j] = seq[W+j] ^ (pred_bit & FIB_OK);
            end
        end
        hist_next = seq[W+D-1:D];
    end

    assign word_err = |err_vec;
    assign count_en = data_valid && (state_q == ST_LOCKED) && word_err;

    always_comb begin
        state_d        = state_q;
        run_d          = run_q;
        hist_d         = hist_q;
        err_out_d      = err_out_q;
        err_valid_d    = data_valid;
        err_word_cnt_d = err_word_cnt_q;
        if (data_valid) begin
            hist_d    = hist_next;
            err_out_d = err_vec;
            case (state_q)
                ST_HUNT: begin
                    if (word_err) begin
                        run_d = '0;
                    end else if (run_q == LOCK_LAST) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                default: begin
                    if (!word_err) begin
                        run_d = '0;
                    end else if (run_q == UNLOCK_LAST) begin
                        state_d = ST_HUNT;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
            endcase
        end
        // clear wins over a coincident errored word
        if (clear_cnt) begin
            err_word_cnt_d = '0;
        end else if (count_en && (err_word_cnt_q != CNT_MAX)) begin
            err_word_cnt_d = err_word_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_HUNT;
            run_q          <= '0;
            hist_q         <= '0;
            err_out_q      <= '0;
            err_valid_q    <= 1'b0;
            err_word_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            hist_q         <= hist_d;
            err_out_q      <= err_out_d;
            err_valid_q    <= err_valid_d;
            err_word_cnt_q <= err_word_cnt_d;
        end
    end

    assign err_out      = err_out_q;
    assign err_valid    = err_valid_q;
    assign locked       = (state_q == ST_LOCKED);
    assign err_word_cnt = err_word_cnt_q;

`ifdef PRBS_MON_BER_EN
    localparam int PC_W  = $clog2(D + 1);
    localparam int SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;

    logic [PC_W-1:0]      err_pop;
    logic [SUM_W-1:0]     bit_sum;
    logic [CNT_WIDTH-1:0] err_bit_cnt_q, err_bit_cnt_d;

    always_comb begin
        err_pop = '0;
        for (int j = 0; j < D; j++) begin
            err_pop = err_pop + PC_W'(err_vec[j]);
        end
        bit_sum       = SUM_W'(err_bit_cnt_q) + SUM_W'(err_pop);
        err_bit_cnt_d = err_bit_cnt_q;
        if (clear_cnt) begin
            err_bit_cnt_d = '0;
        end else if (count_en) begin
            err_bit_cnt_d = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_bit_cnt_q <= '0;
        end else begin
            err_bit_cnt_q <= err_bit_cnt_d;
        end
    end

    assign err_bit_cnt = err_bit_cnt_q;
`else
    assign err_bit_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_mon.sv
// tb/tb_lfsr_prbs_mon.sv - self-checking bench for lfsr_prbs_mon (PRBS31, 64-bit, plus a CNT_WIDTH=4 copy)
module tb_lfsr_prbs_mon;

`ifdef PRBS_MON_BER_EN
    localparam bit BER = 1'b1;
`else
    localparam bit BER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [63:0] data_in = '0;
    logic        clear_cnt = 1'b0;

    logic [63:0] err_out, err_out4;
    logic        err_valid, err_valid4, locked, locked4;
    logic [31:0] wcnt, bcnt;
    logic [3:0]  wcnt4, bcnt4;

    always #5 clk = ~clk;

    lfsr_prbs_mon dut (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
        .clear_cnt(clear_cnt), .err_out(err_out), .err_valid(err_valid),
        .locked(locked), .err_word_cnt(wcnt), .err_bit_cnt(bcnt)
    );

    lfsr_prbs_mon #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
        .clear_cnt(clear_cnt), .err_out(err_out4), .err_valid(err_valid4),
        .locked(locked4), .err_word_cnt(wcnt4), .err_bit_cnt(bcnt4)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: received-bit queue, PRBS31 rule b[n] = b[n-3] ^ b[n-31]
    bit          mhist[$];
    bit          ghist[$];
    int          m_state = 0;
    int          m_run = 0;
    longint      m_w = 0, m_b = 0, m_w4 = 0, m_b4 = 0;
    logic [63:0] exp_err_out = '0;
    logic        exp_err_valid = 1'b0;

    function automatic longint sat(input longint x, input longint mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_reset();
        mhist.delete();
        repeat (31) mhist.push_back(1'b0);
        m_state = 0;
        m_run = 0;
        m_w = 0; m_b = 0; m_w4 = 0; m_b4 = 0;
        exp_err_out = '0;
        exp_err_valid = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [63:0] d, input logic c);
        logic [63:0] e;
        int nb;
        bit was_locked;
        was_locked = (m_state == 1);
        exp_err_valid = v;
        e = '0;
        nb = 0;
        if (v) begin
            for (int j = 0; j < 64; j++) begin
                e[j] = d[j] ^ mhist[28] ^ mhist[0];
                mhist.push_back(d[j]);
                void'(mhist.pop_front());
            end
            exp_err_out = e;
            nb = $countones(e);
            if (m_state == 0) begin
                if (e != 0) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == 16) begin m_state = 1; m_run = 0; end
                end
            end else begin
                if (e == 0) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == 8) begin m_state = 0; m_run = 0; end
                end
            end
        end
        if (c) begin
            m_w = 0; m_b = 0; m_w4 = 0; m_b4 = 0;
        end else if (v && was_locked && e != 0) begin
            m_w  = sat(m_w + 1, 64'hFFFF_FFFF);
            m_b  = sat(m_b + nb, 64'hFFFF_FFFF);
            m_w4 = sat(m_w4 + 1, 15);
            m_b4 = sat(m_b4 + nb, 15);
        end
    endtask

    task automatic gen(output logic [63:0] w);
        bit nb;
        for (int j = 0; j < 64; j++) begin
            nb = ghist[28] ^ ghist[0];
            w[j] = nb;
            ghist.push_back(nb);
            void'(ghist.pop_front());
        end
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic c);
        @(negedge clk);
        #1;
        data_valid = v;
        data_in = d;
        clear_cnt = c;
        model_step(v, d, c);
    endtask

    always @(negedge clk) begin
        check("err_valid", 64'(err_valid), 64'(exp_err_valid));
        check("err_out", err_out, exp_err_out);
        check("locked", 64'(locked), 64'(m_state));
        check("err_word_cnt", 64'(wcnt), 64'(m_w));
        check("err_bit_cnt", 64'(bcnt), BER ? 64'(m_b) : 64'd0);
        check("err_out4", err_out4, exp_err_out);
        check("locked4", 64'(locked4), 64'(m_state));
        check("err_word_cnt4", 64'(wcnt4), 64'(m_w4));
        check("err_bit_cnt4", 64'(bcnt4), BER ? 64'(m_b4) : 64'd0);
    end

    initial begin
        logic [63:0] w;
        int n, pn;
        logic v, pv;
        model_reset();
        repeat (31) ghist.push_back(1'b1);

        step(1'b0, '0, 1'b0);
        check("rst_err_out", err_out, 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_wcnt", 64'(wcnt), 64'd0);
        rst_n = 1'b1;

        // continuous valid PRBS: lock on the 17th word
        for (int k = 1; k <= 20; k++) begin
            gen(w);
            step(1'b1, w, 1'b0);
            if (k == 17) check("hunt_w16", 64'(locked), 64'd0);
            if (k == 18) begin
                check("lock_w17", 64'(locked), 64'd1);
                check("lock_wcnt0", 64'(wcnt), 64'd0);
            end
        end

        // single flipped line bit: 3 error bits at 5, 8 and 36
        gen(w); w[5] = ~w[5];
        step(1'b1, w, 1'b0);
        gen(w);
        step(1'b1, w, 1'b0);
        check("flip_err_out", err_out, 64'h0000_0010_0000_0120);
        check("flip_wcnt", 64'(wcnt), 64'd1);
        check("flip_bcnt", 64'(bcnt), BER ? 64'd3 : 64'd0);
        check("flip_locked", 64'(locked), 64'd1);

        // 20 more errored words interleaved with clean ones: narrow counters saturate
        repeat (20) begin
            gen(w); w[5] = ~w[5];
            step(1'b1, w, 1'b0);
            gen(w);
            step(1'b1, w, 1'b0);
        end
        step(1'b0, '0, 1'b0);
        check("sat_wcnt4", 64'(wcnt4), 64'd15);
        check("sat_bcnt4", 64'(bcnt4), BER ? 64'd15 : 64'd0);
        check("wide_wcnt", 64'(wcnt), 64'd21);
        check("wide_bcnt", 64'(bcnt), BER ? 64'd63 : 64'd0);

        // clear coincident with an errored word
        gen(w); w[5] = ~w[5];
        step(1'b1, w, 1'b1);
        step(1'b0, '0, 1'b0);
        check("clr_wcnt", 64'(wcnt), 64'd0);
        check("clr_bcnt", 64'(bcnt), 64'd0);
        check("clr_wcnt4", 64'(wcnt4), 64'd0);
        check("clr_locked", 64'(locked), 64'd1);
        gen(w);
        step(1'b1, w, 1'b0);

        // 8 random words drop lock on the 8th
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, {$urandom, $urandom}, 1'b0);
            if (k == 8) check("rand7_locked", 64'(locked), 64'd1);
        end
        step(1'b0, '0, 1'b0);
        check("rand8_unlock", 64'(locked), 64'd0);
        check("rand8_wcnt", 64'(wcnt), 64'd8);

        // resume stream, then reset asynchronously between edges
        for (int k = 0; k < 3; k++) begin
            gen(w);
            if (k == 2) w[10] = ~w[10];
            step(1'b1, w, 1'b0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        data_valid = 1'b0;
        model_reset();
        #1;
        check("mid_rst_err_out", err_out, 64'd0);
        check("mid_rst_err_valid", 64'(err_valid), 64'd0);
        check("mid_rst_locked", 64'(locked), 64'd0);
        check("mid_rst_wcnt", 64'(wcnt), 64'd0);
        check("mid_rst_wcnt4", 64'(wcnt4), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // relock with gaps in data_valid: exactly 17 valid words
        n = 0; pn = 0; pv = 1'b0;
        for (int k = 0; k < 40; k++) begin
            v = (k % 3 != 1);
            if (v) begin
                gen(w);
                n++;
            end else begin
                w = {$urandom, $urandom};
            end
            step(v, w, 1'b0);
            if (pv && pn == 16) check("relock_w16", 64'(locked), 64'd0);
            if (pv && pn == 17) check("relock_w17", 64'(locked), 64'd1);
            pv = v;
            pn = n;
        end
        step(1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
